// File: rtl/sd_line_server_if.sv
// Memory beat port between the line server (master) and the memory model (slave).
interface sd_line_server_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WORD_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/sd_line_server.sv
// Cache line-miss responder: optional 4-beat victim writeback, then 4-beat line read,
// then a one-cycle fill strobe with the assembled line.
module sd_line_server #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WORD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_req,
  input  logic [ADDR_W-1:0]   miss_addr,
  input  logic                wb_req,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [4*WORD_W-1:0] wb_data,
  output logic [4*WORD_W-1:0] fill_data,
  output logic                fill_we,
  output logic                busy,
  sd_line_server_if.master    mem
);
  localparam int unsigned LINE_W = 4 * WORD_W;
  // Clears the word-in-line bits so a latched address is a line base.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(3);

  typedef enum logic [2:0] {IDLE, WB, RD, FILL, HOLD} state_t;

  state_t                   state, state_n;
  logic [1:0]               beat, beat_n;
  logic [ADDR_W-1:0]        line, line_n;
  logic [ADDR_W-1:0]        wb_line, wb_line_n;
  logic [3:0][WORD_W-1:0]   wb_buf, wb_buf_n;
  logic [2:0][WORD_W-1:0]   rd_buf, rd_buf_n;
  logic [LINE_W-1:0]        fill_data_n;
  logic                     fill_we_n;
  logic                     busy_n;
  logic                     req_n;
  logic                     we_n;
  logic [ADDR_W-1:0]        addr_n;
  logic [WORD_W-1:0]        wdata_n;
  logic                     ack_beat;

  assign ack_beat = mem.mem_req & mem.mem_ack;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      beat          <= 2'd0;
      line          <= '0;
      wb_line       <= '0;
      wb_buf        <= '0;
      rd_buf        <= '0;
      fill_data     <= '0;
      fill_we       <= 1'b0;
      busy          <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      state         <= state_n;
      beat          <= beat_n;
      line          <= line_n;
      wb_line       <= wb_line_n;
      wb_buf        <= wb_buf_n;
      rd_buf        <= rd_buf_n;
      fill_data     <= fill_data_n;
      fill_we       <= fill_we_n;
      busy          <= busy_n;
      mem.mem_req   <= req_n;
      mem.mem_we    <= we_n;
      mem.mem_addr  <= addr_n;
      mem.mem_wdata <= wdata_n;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_n     = state;
    beat_n      = beat;
    line_n      = line;
    wb_line_n   = wb_line;
    wb_buf_n    = wb_buf;
    rd_buf_n    = rd_buf;
    fill_data_n = fill_data;
    fill_we_n   = 1'b0;
    req_n       = mem.mem_req;
    we_n        = mem.mem_we;
    addr_n      = mem.mem_addr;
    wdata_n     = mem.mem_wdata;

    case (state)
      IDLE: begin
        if (miss_req) begin
          line_n    = miss_addr & LINE_MASK;
          wb_line_n = wb_addr & LINE_MASK;
          wb_buf_n  = wb_data;
          beat_n    = 2'd0;
          req_n     = 1'b1;
          if (wb_req) begin
            state_n = WB;
            we_n    = 1'b1;
            addr_n  = wb_line_n;
            wdata_n = wb_data[WORD_W-1:0];
          end else begin
            state_n = RD;
            we_n    = 1'b0;
            addr_n  = line_n;
          end
        end
      end
      WB: begin
        if (ack_beat) begin
          beat_n = beat + 2'd1;
          if (beat == 2'd3) begin
            // Counter has wrapped to 0; first read beat follows back-to-back.
            state_n = RD;
            we_n    = 1'b0;
            addr_n  = line | ADDR_W'(beat_n);
          end else begin
            addr_n  = wb_line | ADDR_W'(beat_n);
            wdata_n = wb_buf[beat_n];
          end
        end
      end
      RD: begin
        if (ack_beat) begin
          beat_n = beat + 2'd1;
          case (beat)
            2'd0:    rd_buf_n[0] = mem.mem_rdata;
            2'd1:    rd_buf_n[1] = mem.mem_rdata;
            2'd2:    rd_buf_n[2] = mem.mem_rdata;
            default: ;
          endcase
          if (beat == 2'd3) begin
            state_n     = FILL;
            req_n       = 1'b0;
            fill_we_n   = 1'b1;
            fill_data_n = {mem.mem_rdata, rd_buf[2], rd_buf[1], rd_buf[0]};
          end else begin
            addr_n = line | ADDR_W'(beat_n);
          end
        end
      end
      FILL:    state_n = HOLD;
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end
endmodule

// File: tb/tb_sd_line_server.sv
// Scoreboard bench for sd_line_server: directed misses against a memory model
// with programmable wait states.
module tb_sd_line_server;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WORD_W = 16;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } beat_t;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] cyc;
  } fill_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [15:0] miss_addr;
  logic        wb_req;
  logic [15:0] wb_addr;
  logic [63:0] wb_data;
  logic [63:0] fill_data;
  logic        fill_we;
  logic        busy;

  sd_line_server_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) mif ();

  sd_line_server #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .miss_req  (miss_req),
    .miss_addr (miss_addr),
    .wb_req    (wb_req),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .fill_data (fill_data),
    .fill_we   (fill_we),
    .busy      (busy),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  // Memory model: ack after wait_cyc cycles of mem_req, combinational read data.
  logic [15:0] mem_arr [0:1023];
  int wait_cyc = 0;
  int wcnt = 0;

  assign mif.mem_ack   = mif.mem_req && (wcnt == wait_cyc);
  assign mif.mem_rdata = mif.mem_req ? mem_arr[mif.mem_addr[9:0]] : 16'h0000;

  always @(posedge clk) begin
    if (mif.mem_req && mif.mem_ack) begin
      if (mif.mem_we) mem_arr[mif.mem_addr[9:0]] <= mif.mem_wdata;
      wcnt <= 0;
    end else if (mif.mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    checks = 0;
  int    errors = 0;
  int    fills_seen = 0;
  beat_t beat_q[$];
  fill_t fill_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: completed beats, fill strobes and beat stability while waiting.
  beat_t mb;
  fill_t mf;
  beat_t held;
  bit    waiting = 1'b0;

  always @(negedge clk) begin
    if (!rst && mif.mem_req && mif.mem_ack) begin
      if (beat_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got addr %h we %b, no beat expected", mif.mem_addr, mif.mem_we);
      end else begin
        mb = beat_q.pop_front();
        chk("beat_we", 64'(mif.mem_we), 64'(mb.we));
        chk("beat_addr", 64'(mif.mem_addr), 64'(mb.addr));
        if (mb.we) chk("beat_wdata", 64'(mif.mem_wdata), 64'(mb.wdata));
      end
    end
    if (fill_we) begin
      fills_seen++;
      if (fill_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_fill: got data %h, no fill expected", fill_data);
      end else begin
        mf = fill_q.pop_front();
        chk("fill_data", fill_data, mf.data);
        chk("fill_cycle", 64'(cyc), 64'(mf.cyc));
      end
    end
    if (!rst && mif.mem_req) begin
      if (waiting) begin
        chk("stall_addr", 64'(mif.mem_addr), 64'(held.addr));
        chk("stall_we", 64'(mif.mem_we), 64'(held.we));
        chk("stall_wdata", 64'(mif.mem_wdata), 64'(held.wdata));
      end
      waiting = !mif.mem_ack;
      held    = '{we: mif.mem_we, addr: mif.mem_addr, wdata: mif.mem_wdata};
    end else begin
      waiting = 1'b0;
    end
  end

  task automatic push_beats(input logic [15:0] ma, input logic wr, input logic [15:0] wa,
                            input logic [63:0] wd);
    if (wr)
      for (int i = 0; i < 4; i++)
        beat_q.push_back('{we: 1'b1, addr: {wa[15:2], 2'(i)}, wdata: wd[16*i +: 16]});
    for (int i = 0; i < 4; i++)
      beat_q.push_back('{we: 1'b0, addr: {ma[15:2], 2'(i)}, wdata: 16'h0000});
  endtask

  task automatic do_miss(input logic [15:0] ma, input logic wr, input logic [15:0] wa,
                         input logic [63:0] wd, input logic [63:0] line, input int lat,
                         input bit hold, output int t0);
    @(negedge clk);
    miss_addr = ma;
    wb_req    = wr;
    wb_addr   = wa;
    wb_data   = wd;
    miss_req  = 1'b1;
    t0        = cyc;
    push_beats(ma, wr, wa, wd);
    fill_q.push_back('{data: line, cyc: 32'(t0 + lat)});
    if (!hold) begin
      @(negedge clk);
      miss_req = 1'b0;
    end
  endtask

  task automatic wait_fills(input int n);
    for (int k = 0; k < 200 && fills_seen < n; k++) @(negedge clk);
    if (fills_seen < n) begin
      checks++; errors++;
      $display("FAIL fill_timeout: got %0d fills expected %0d", fills_seen, n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog");
  end

  int t0;

  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = 16'h0000;
    mem_arr[10'h100] = 16'h1111; mem_arr[10'h101] = 16'h2222;
    mem_arr[10'h102] = 16'h3333; mem_arr[10'h103] = 16'h4444;
    mem_arr[10'h110] = 16'h5555; mem_arr[10'h111] = 16'h6666;
    mem_arr[10'h112] = 16'h7777; mem_arr[10'h113] = 16'h8888;
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; wb_req = 1'b0; wb_addr = '0; wb_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_mem_req", 64'(mif.mem_req), 64'd0);
    chk("rst_mem_we", 64'(mif.mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mif.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mif.mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fill_we", 64'(fill_we), 64'd0);
    chk("rst_fill_data", fill_data, 64'd0);
    rst = 1'b0;

    // Clean miss, zero-wait memory.
    do_miss(16'h0102, 1'b0, 16'h0000, 64'h0, 64'h4444_3333_2222_1111, 5, 1'b0, t0);
    wait_fills(1);
    while (cyc < t0 + 6) @(negedge clk);
    chk("clean_busy_hold", 64'(busy), 64'd1);
    @(negedge clk);
    chk("clean_busy_idle", 64'(busy), 64'd0);
    chk("clean_req_idle", 64'(mif.mem_req), 64'd0);
    chk("clean_fill_held", fill_data, 64'h4444_3333_2222_1111);

    // Dirty miss: writeback to 0x0200 precedes read of 0x0100.
    do_miss(16'h0101, 1'b1, 16'h0200, 64'hDDDD_CCCC_BBBB_AAAA, 64'h4444_3333_2222_1111, 9, 1'b0, t0);
    wait_fills(2);
    repeat (3) @(negedge clk);
    chk("wb_mem_0200", 64'(mem_arr[10'h200]), 64'hAAAA);
    chk("wb_mem_0203", 64'(mem_arr[10'h203]), 64'hDDDD);

    // Two wait cycles per beat.
    wait_cyc = 2;
    do_miss(16'h0111, 1'b0, 16'h0000, 64'h0, 64'h8888_7777_6666_5555, 13, 1'b0, t0);
    wait_fills(3);
    repeat (3) @(negedge clk);
    wait_cyc = 0;

    // Writeback to the same line that is then read back.
    do_miss(16'h0302, 1'b1, 16'h0301, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 9, 1'b0, t0);
    wait_fills(4);
    repeat (3) @(negedge clk);

    // miss_req held through HOLD: a second miss is accepted only from IDLE,
    // and dropping miss_req mid-transaction does not abort it.
    do_miss(16'h0100, 1'b0, 16'h0000, 64'h0, 64'h4444_3333_2222_1111, 5, 1'b1, t0);
    push_beats(16'h0100, 1'b0, 16'h0000, 64'h0);
    fill_q.push_back('{data: 64'h4444_3333_2222_1111, cyc: 32'(t0 + 12)});
    while (cyc < t0 + 7) @(negedge clk);
    chk("retrig_idle_gap", 64'(busy), 64'd0);
    @(negedge clk);
    chk("retrig_second_start", 64'(busy), 64'd1);
    miss_req = 1'b0;
    wait_fills(6);
    repeat (10) @(negedge clk);
    chk("retrig_fill_count", 64'(fills_seen), 64'd6);

    // Reset while read beat 2 is outstanding.
    @(negedge clk);
    miss_addr = 16'h0110; wb_req = 1'b0; miss_req = 1'b1;
    beat_q.push_back('{we: 1'b0, addr: 16'h0110, wdata: 16'h0000});
    beat_q.push_back('{we: 1'b0, addr: 16'h0111, wdata: 16'h0000});
    @(negedge clk);
    miss_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_addr", 64'(mif.mem_addr), 64'h0112);
    rst = 1'b1;
    #1;
    chk("midrst_mem_req", 64'(mif.mem_req), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_fill_data", fill_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_no_fill", 64'(fills_seen), 64'd6);
    chk("midrst_fill_data_after", fill_data, 64'd0);
    chk("beat_queue_empty", 64'(beat_q.size()), 64'd0);
    chk("fill_queue_empty", 64'(fill_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
